// File: rtl/bp_pht_update_ctrl.sv
// gshare PHT update sequencer: queues M-stage resolutions, owns the retired GHR,
// and drives a single sync-read RAM port (init sweep, then read-modify-write).
module bp_pht_update_ctrl #(
  parameter int unsigned PHT_DEPTH  = 6,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 branchM,
  input  logic                 actual_takeM,
  input  logic                 pred_takeM,
  input  logic [31:0]          pcM,
  output logic [PHT_DEPTH-1:0] pht_addr,
  output logic                 pht_we,
  output logic [1:0]           pht_wdata,
  input  logic [1:0]           pht_rdata,
  output logic [PHT_DEPTH-1:0] ghr_retire,
  output logic                 recover,
  output logic                 stall,
  output logic                 init_busy,
  output logic                 overflow,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_WRITE} state_t;

  state_t                 state_q, state_d;
  logic [PHT_DEPTH-1:0]   sweep_q, sweep_d;
  logic [PHT_DEPTH-1:0]   fifo_idx_q [FIFO_DEPTH];
  logic                   fifo_tk_q  [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [PHT_DEPTH-1:0]   work_idx_q;
  logic                   work_tk_q;
  logic [PHT_DEPTH-1:0]   ghr_q;
  logic [31:0]            bcnt_q, mcnt_q;
  logic                   ovf_q, rec_q;

  logic                   in_init, br_ok, full, push, pop;
  logic [PHT_DEPTH-1:0]   enq_idx;
  logic [1:0]             sat_val;
  logic                   unused_pc;

  assign unused_pc = ^{pcM[31:PHT_DEPTH+2], pcM[1:0]};

  assign in_init = (state_q == S_INIT);
  assign br_ok   = branchM & ~in_init;
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign push    = br_ok & ~full;
  assign enq_idx = pcM[PHT_DEPTH+1:2] ^ ghr_q;

  always_comb begin
    sat_val = pht_rdata;
    if (work_tk_q) begin
      if (pht_rdata != 2'b11) sat_val = pht_rdata + 2'd1;
    end else begin
      if (pht_rdata != 2'b00) sat_val = pht_rdata - 2'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    pop       = 1'b0;
    pht_addr  = '0;
    pht_we    = 1'b0;
    pht_wdata = 2'b10;
    case (state_q)
      S_INIT: begin
        pht_addr = sweep_q;
        pht_we   = 1'b1;
        sweep_d  = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_READ;
        end
      end
      S_READ: begin
        pht_addr = work_idx_q;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        pht_addr  = work_idx_q;
        pht_we    = 1'b1;
        pht_wdata = sat_val;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
    // reset is synchronous, so suppress the in-flight write combinationally
    if (rst) pht_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      work_idx_q <= '0;
      work_tk_q  <= 1'b0;
      ghr_q      <= '0;
      bcnt_q     <= '0;
      mcnt_q     <= '0;
      ovf_q      <= 1'b0;
      rec_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      if (push) begin
        fifo_idx_q[wr_ptr_q] <= enq_idx;
        fifo_tk_q[wr_ptr_q]  <= actual_takeM;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        work_idx_q <= fifo_idx_q[rd_ptr_q];
        work_tk_q  <= fifo_tk_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      rec_q   <= br_ok & (actual_takeM != pred_takeM);
      if (br_ok) begin
        ghr_q  <= {ghr_q[PHT_DEPTH-2:0], actual_takeM};
        bcnt_q <= bcnt_q + 32'd1;
        if (actual_takeM != pred_takeM) mcnt_q <= mcnt_q + 32'd1;
        if (full) ovf_q <= 1'b1;
      end
    end
  end

  assign ghr_retire  = ghr_q;
  assign recover     = rec_q;
  assign overflow    = ovf_q;
  assign branch_cnt  = bcnt_q;
  assign mispred_cnt = mcnt_q;
  assign init_busy   = rst | in_init;
  assign stall       = rst | in_init | (count_q >= CW'(FIFO_DEPTH - 1));

endmodule

// File: tb/tb_bp_pht_update_ctrl.sv
// Directed bench for bp_pht_update_ctrl: RAM model plus a scoreboard of expected
// PHT writes, filled as branches are driven and drained as the DUT writes.
module tb_bp_pht_update_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branchM = 1'b0, actual_takeM = 1'b0, pred_takeM = 1'b0;
  logic [31:0] pcM = '0;
  logic [5:0]  pht_addr;
  logic        pht_we;
  logic [1:0]  pht_wdata;
  logic [1:0]  pht_rdata = 2'b00;
  logic [5:0]  ghr_retire;
  logic        recover, stall, init_busy, overflow;
  logic [31:0] branch_cnt, mispred_cnt;

  bp_pht_update_ctrl #(.PHT_DEPTH(6), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .branchM(branchM), .actual_takeM(actual_takeM),
    .pred_takeM(pred_takeM), .pcM(pcM), .pht_addr(pht_addr), .pht_we(pht_we),
    .pht_wdata(pht_wdata), .pht_rdata(pht_rdata), .ghr_retire(ghr_retire),
    .recover(recover), .stall(stall), .init_busy(init_busy), .overflow(overflow),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  logic [1:0] mem [64];
  always @(posedge clk) begin
    if (pht_we) mem[pht_addr] <= pht_wdata;
    pht_rdata <= mem[pht_addr];
  end

  int          errors = 0, checks = 0, n_accept = 0, n_writes = 0;
  logic [7:0]  sb [$];
  logic [1:0]  ref_pht [64];
  logic [5:0]  ghr_m = '0;
  logic [31:0] bcnt_m = '0, mcnt_m = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard side: every post-init PHT write must match the next expected entry
  always @(negedge clk) begin
    if (!rst && !init_busy && pht_we) begin
      logic [7:0] exp_w;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write: observed=%0h expected=none", {pht_addr, pht_wdata});
      end else begin
        exp_w = sb.pop_front();
        n_writes++;
        assert ({pht_addr, pht_wdata} === exp_w) else begin
          errors++;
          $error("FAIL pht_write: observed=%0h expected=%0h", {pht_addr, pht_wdata}, exp_w);
        end
      end
    end
  end

  function automatic logic [1:0] next_ctr(input logic [1:0] c, input logic tk);
    logic [1:0] up [4];
    logic [1:0] dn [4];
    up = '{2'b01, 2'b10, 2'b11, 2'b11};
    dn = '{2'b00, 2'b00, 2'b01, 2'b10};
    return tk ? up[c] : dn[c];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_branch(input logic [5:0] idx, input logic tk, input logic pd,
                              input bit drop);
    pcM          = {24'h0, idx ^ ghr_m, 2'b00};
    branchM      = 1'b1;
    actual_takeM = tk;
    pred_takeM   = pd;
    if (!drop) begin
      ref_pht[idx] = next_ctr(ref_pht[idx], tk);
      sb.push_back({idx, ref_pht[idx]});
      n_accept++;
    end
    ghr_m = {ghr_m[4:0], tk};
    bcnt_m++;
    if (tk != pd) mcnt_m++;
  endtask

  task automatic one_branch(input logic [5:0] idx, input logic tk, input logic pd);
    drive_branch(idx, tk, pd, 1'b0);
    tick();
    branchM = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic reset_model();
    for (int i = 0; i < 64; i++) ref_pht[i] = 2'b10;
    ghr_m  = '0;
    bcnt_m = '0;
    mcnt_m = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_model();
    // 1: reset and init sweep
    tick();
    @(negedge clk);
    check("rst_init_busy", init_busy, 1);
    check("rst_stall", stall, 1);
    check("rst_we", pht_we, 0);
    tick();
    @(negedge clk);
    check("rst_ghr", ghr_retire, 0);
    check("rst_bcnt", branch_cnt, 0);
    check("rst_recover", recover, 0);
    check("rst_overflow", overflow, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      check("init_write", {pht_we, pht_addr, pht_wdata}, {1'b1, 6'(i), 2'b10});
      if (i == 63) check("init_busy_last", init_busy, 1);
      tick();
    end
    @(negedge clk);
    check("init_done_busy", init_busy, 0);
    check("init_done_stall", stall, 0);
    check("idle_we", pht_we, 0);
    check("idle_addr", pht_addr, 0);

    // 2: pcM=0x10, ghr=0 -> index 4, 10 -> 11
    drive_branch(6'd4, 1'b1, 1'b1, 1'b0);
    check("t2_pc", pcM, 32'h10);
    tick();
    branchM = 1'b0;
    @(negedge clk);
    check("t2_ghr", ghr_retire, 6'b000001);
    check("t2_recover", recover, 0);
    check("t2_bcnt", branch_cnt, 1);
    tick();
    @(negedge clk);
    check("t2_read", {pht_we, pht_addr}, {1'b0, 6'd4});
    tick();
    @(negedge clk);
    check("t2_write", {pht_we, pht_addr, pht_wdata}, {1'b1, 6'd4, 2'b11});
    drain();

    // 3: build ghr=101010, then a mispredicted not-taken branch
    one_branch(6'd10, 1'b1, 1'b1); drain();
    one_branch(6'd11, 1'b0, 1'b0); drain();
    one_branch(6'd12, 1'b1, 1'b1); drain();
    one_branch(6'd13, 1'b0, 1'b0); drain();
    one_branch(6'd14, 1'b1, 1'b1); drain();
    one_branch(6'd15, 1'b0, 1'b0); drain();
    @(negedge clk);
    check("t3_ghr_pre", ghr_retire, 6'b101010);
    one_branch(6'd30, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_recover", recover, 1);
    check("t3_ghr", ghr_retire, 6'b010100);
    check("t3_mcnt", mispred_cnt, 1);
    tick();
    @(negedge clk);
    check("t3_recover_low", recover, 0);
    drain();

    // 4: saturation at both ends (checked by the write scoreboard)
    one_branch(6'd9, 1'b1, 1'b1); drain();
    one_branch(6'd9, 1'b1, 1'b1); drain();
    one_branch(6'd20, 1'b0, 1'b0); drain();
    one_branch(6'd20, 1'b0, 1'b0); drain();
    one_branch(6'd20, 1'b0, 1'b0); drain();

    // 5: ten back-to-back branches; cycles 7 and 9 find the queue full
    for (int i = 0; i < 10; i++) begin
      drive_branch(6'(50 + i % 3), 1'(i % 2), 1'(i % 2), (i == 7) || (i == 9));
      @(negedge clk);
      check("t5_stall", stall, (i >= 5) ? 1 : 0);
      if (i == 7) check("t5_ovf_pre", overflow, 0);
      tick();
    end
    branchM = 1'b0;
    @(negedge clk);
    check("t5_overflow", overflow, 1);
    check("t5_bcnt", branch_cnt, bcnt_m);
    check("t5_mcnt", mispred_cnt, mcnt_m);
    drain();
    check("t5_writes", n_writes, n_accept);

    // 6: reset during WRITE with a second entry still queued
    drive_branch(6'd40, 1'b1, 1'b1, 1'b0);
    tick();
    drive_branch(6'd41, 1'b0, 1'b0, 1'b0);
    tick();
    branchM = 1'b0;
    tick();
    rst = 1'b1;
    n_accept -= sb.size();
    sb.delete();
    reset_model();
    @(negedge clk);
    check("t6_we_in_rst", pht_we, 0);
    check("t6_stall", stall, 1);
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_sweep0", {pht_we, pht_addr, pht_wdata}, {1'b1, 6'd0, 2'b10});
    check("t6_ghr", ghr_retire, 0);
    check("t6_bcnt", branch_cnt, 0);
    check("t6_overflow", overflow, 0);
    for (int i = 1; i < 64; i++) tick();
    @(negedge clk);
    check("t6_sweep63", {pht_we, pht_addr}, {1'b1, 6'd63});
    tick();
    @(negedge clk);
    check("t6_init_done", init_busy, 0);
    for (int i = 0; i < 10; i++) tick();
    check("t6_writes", n_writes, n_accept);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
